data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
- Responder for the memory-control signals produced by the main decoder (MemRead, MemWrite). It executes the requested load or store against a word-organised data memory that uses a req/ack handshake.
- Stalls the single-cycle core while an access is in flight.
- Formats load data (byte, half or word, with sign or zero extension) and generates store byte enables.
- Sits between the core datapath (ALU result as address, rs2 as write data) and the data memory.

Parameters:
- TIMEOUT, 16: maximum cycles in ACCESS waiting for mem_ack before the access is aborted with BusErr.
- RESET_RDATA, 32'h0: value of ReadData after reset and on an aborted load.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- MemRead  input  1  load request from the decoder
- MemWrite  input  1  store request from the decoder
- Funct3  input  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- Addr  input  32  byte address (ALU result)
- WriteData  input  32  store data (rs2)
- ReadData  output  32  formatted load result; valid in the DONE cycle
- Stall  output  1  holds the core (PC and register file) while high
- MisalignErr  output  1  one-cycle pulse on a misaligned access
- BusErr  output  1  one-cycle pulse on a timeout abort
- mem_req  output  1  memory request; held high until mem_ack
- mem_we  output  1  1 for a store, 0 for a load
- mem_addr  output  32  word address, {Addr[31:2],2'b00}
- mem_wdata  output  32  store data lane-replicated
- mem_be  output  4  byte enables; 4'b0000 for loads
- mem_ack  input  1  memory completion; sampled only while mem_req is high
- mem_rdata  input  32  raw word; valid in the mem_ack cycle

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous and active-high. On reset the FSM enters IDLE and all outputs take these values: Stall=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, MisalignErr=0, BusErr=0, ReadData=RESET_RDATA.
- Reset mid-access: mem_req drops at the same edge. Any late mem_ack is ignored.
- FSM has three states: IDLE, ACCESS, DONE.
- Request definition: req = MemRead | MemWrite. If both are high, the access is treated as a store.
- Alignment rule: misaligned when Funct3 size is half and Addr[0]=1, or size is word and Addr[1:0]!=0.
- IDLE, req and aligned:
  - Stall=1 combinationally in the same cycle.
  - At the next edge: latch Addr[1:0], Funct3 and the type; drive mem_req=1 with mem_addr, mem_we, mem_be and mem_wdata; go to ACCESS.
- IDLE, req and misaligned:
  - No memory access. Stall=0.
  - MisalignErr=1 registered for one cycle. State stays IDLE.
- IDLE, no req: all request outputs idle.
- ACCESS:
  - Stall=1 and mem_req=1; request fields held stable.
  - On mem_ack=1: capture the formatted load data into ReadData, drop mem_req at that edge, go to DONE.
  - The cycle counter counts ACCESS cycles. When TIMEOUT cycles pass without ack: drop mem_req, set ReadData=RESET_RDATA for a load, pulse BusErr, go to DONE.
- DONE:
  - Exactly one cycle with Stall=0; the core commits at the end of this cycle.
  - Inputs are ignored. The next state is IDLE unconditionally, so a back-to-back access starts a new IDLE evaluation.
- Latency: an access with ack in its first ACCESS cycle gives IDLE (stall) → ACCESS → DONE, i.e. 2 stall cycles.
- Store lanes:
  - SB: mem_be=4'b0001<<Addr[1:0], mem_wdata={4{WriteData[7:0]}}.
  - SH: mem_be=4'b0011<<Addr[1:0], mem_wdata={2{WriteData[15:0]}}.
  - SW: mem_be=4'b1111, mem_wdata=WriteData.
- Load extraction:
  - Select the byte or half by the latched Addr[1:0].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- Unsupported Funct3 (011, 110, 111) with req: treated as a word access.
- ReadData holds its last value outside the DONE update.

Test Plan:
- Reset then LW Addr=0x100; mem_ack on the 1st ACCESS cycle with mem_rdata=0xDEADBEEF → mem_addr=0x100, mem_be=0, Stall high 2 cycles, ReadData=0xDEADBEEF in DONE.
- LB Addr=0x203, mem_rdata=0x80FF1234 → ReadData=0xFFFFFF80. LBU at the same address → 0x00000080. LHU Addr=0x202 → 0x000080FF.
- SB Addr=0x301, WriteData=0x000000AB → mem_we=1, mem_be=4'b0010, mem_wdata=0xABABABAB, mem_addr=0x300. SH Addr=0x302 → mem_be=4'b1100.
- LW Addr=0x101 → no mem_req, Stall stays 0, MisalignErr pulses 1 cycle. SH Addr=0x103 → same.
- Hold mem_ack=0 → mem_req high exactly TIMEOUT=16 cycles, then BusErr pulse, ReadData=0, DONE, IDLE.
- Assert reset during ACCESS (cycle 3 of 5 before ack) → mem_req=0, Stall=0 after that edge; a late ack is ignored. Back-to-back LW/SW re-enters ACCESS right after DONE.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Load/store responder between the single-cycle core and a req/ack word memory.
// Stalls the core while an access is in flight, formats load data and drives store lanes.
module data_mem_ctrl #(
    parameter int unsigned TIMEOUT     = 16,
    parameter logic [31:0] RESET_RDATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        MisalignErr,
    output logic        BusErr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT > 32'd1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 32'd1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Size code: 0 byte, 1 half, 2 word; the low two Funct3 bits map 011/110/111 to word
    function automatic logic [1:0] size_of(input logic [2:0] f3);
        logic [1:0] s;
        case (f3[1:0])
            2'b00:   s = 2'd0;
            2'b01:   s = 2'd1;
            default: s = 2'd2;
        endcase
        return s;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic m;
        case (size_of(f3))
            2'd0:    m = 1'b0;
            2'd1:    m = off[0];
            default: m = (off != 2'b00);
        endcase
        return m;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (size_of(f3))
            2'd0:    be = 4'b0001 << off;
            2'd1:    be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (size_of(f3))
            2'd0:    d = {4{wd[7:0]}};
            2'd1:    d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] format_load(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'h00_0000, b};
            3'b101:  r = {16'h0000, h};
            default: r = w;
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  f3_q, f3_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        misalign_q, misalign_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] read_data_q, read_data_d;
    logic        stall_s;
    logic        req_s;
    logic        store_s;

    assign req_s   = MemRead | MemWrite;
    assign store_s = MemWrite;

    // Next-state, request fields, load capture and the combinational stall
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        off_d       = off_q;
        f3_d        = f3_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;
        read_data_d = read_data_q;
        stall_s     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_s && is_misaligned(Funct3, Addr[1:0])) begin
                    misalign_d = 1'b1;
                end else if (req_s) begin
                    stall_s     = 1'b1;
                    state_d     = ACCESS;
                    cnt_d       = '0;
                    off_d       = Addr[1:0];
                    f3_d        = Funct3;
                    mem_req_d   = 1'b1;
                    mem_we_d    = store_s;
                    mem_addr_d  = {Addr[31:2], 2'b00};
                    mem_be_d    = store_s ? store_be(Funct3, Addr[1:0]) : 4'b0000;
                    mem_wdata_d = store_s ? store_lanes(Funct3, WriteData) : 32'h0000_0000;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                stall_s = 1'b1;
                if (mem_ack || (cnt_q == CNT_LAST)) begin
                    // Ack wins over a timeout landing in the same cycle
                    state_d     = DONE;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = 32'h0000_0000;
                    mem_wdata_d = 32'h0000_0000;
                    mem_be_d    = 4'b0000;
                    bus_err_d   = ~mem_ack;
                    if (mem_we_q) begin
                        read_data_d = read_data_q;
                    end else if (mem_ack) begin
                        read_data_d = format_load(f3_q, off_q, mem_rdata);
                    end else begin
                        read_data_d = RESET_RDATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            off_q       <= 2'b00;
            f3_q        <= 3'b000;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
            mem_be_q    <= 4'b0000;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            read_data_q <= RESET_RDATA;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            off_q       <= off_d;
            f3_q        <= f3_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
            read_data_q <= read_data_d;
        end
    end

    assign ReadData    = read_data_q;
    assign Stall       = stall_s;
    assign MisalignErr = misalign_q;
    assign BusErr      = bus_err_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_be      = mem_be_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: expected load results queued at drive time,
// popped and compared in the DONE cycle.
module tb_data_mem_ctrl;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        MisalignErr;
    logic        BusErr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks;
    int failures;
    logic [31:0] exp_q[$];

    data_mem_ctrl #(.TIMEOUT(16), .RESET_RDATA(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .Funct3(Funct3), .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData),
        .Stall(Stall), .MisalignErr(MisalignErr), .BusErr(BusErr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_access(input string name, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd, input int ack_cyc,
                              input logic [31:0] rdata, input logic [31:0] exp_addr,
                              input logic [31:0] exp_wdata, input logic [3:0] exp_be,
                              input logic [31:0] exp_rd);
        int stalls;
        logic [31:0] e;
        stalls = 0;
        MemRead = ~wr; MemWrite = wr; Funct3 = f3; Addr = addr; WriteData = wd;
        exp_q.push_back(exp_rd);
        @(negedge clk);
        if (Stall) stalls++;
        chk({name, "_idle_req"}, {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < ack_cyc; i++) begin
            @(negedge clk);
            if (Stall) stalls++;
            chk({name, "_req_wait"}, {31'd0, mem_req}, 32'd1);
            @(posedge clk); #1;
        end
        mem_ack = 1'b1; mem_rdata = rdata;
        @(negedge clk);
        if (Stall) stalls++;
        chk({name, "_req"},   {31'd0, mem_req}, 32'd1);
        chk({name, "_addr"},  mem_addr, exp_addr);
        chk({name, "_we"},    {31'd0, mem_we}, {31'd0, wr});
        chk({name, "_be"},    {28'd0, mem_be}, {28'd0, exp_be});
        chk({name, "_wdata"}, mem_wdata, exp_wdata);
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = 32'h0000_0000;
        @(negedge clk);
        if (Stall) stalls++;
        e = exp_q.pop_front();
        chk({name, "_rdata"},  ReadData, e);
        chk({name, "_req_off"}, {31'd0, mem_req}, 32'd0);
        chk({name, "_buserr"}, {31'd0, BusErr}, 32'd0);
        chk({name, "_stalls"}, stalls, 32'(2 + ack_cyc));
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic run_misalign(input string name, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr);
        MemRead = ~wr; MemWrite = wr; Funct3 = f3; Addr = addr; WriteData = 32'h1111_2222;
        @(negedge clk);
        chk({name, "_stall"}, {31'd0, Stall}, 32'd0);
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0;
        @(negedge clk);
        chk({name, "_mis"}, {31'd0, MisalignErr}, 32'd1);
        chk({name, "_req"}, {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({name, "_mis_end"}, {31'd0, MisalignErr}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        checks = 0; failures = 0;
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b000;
        Addr = 32'h0; WriteData = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_stall", {31'd0, Stall}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_be", {28'd0, mem_be}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_rdata", ReadData, 32'd0);
        chk("rst_errs", {30'd0, MisalignErr, BusErr}, 32'd0);
        @(posedge clk); #1;

        run_access("lw",  1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, 32'h100, 32'h0, 4'b0000, 32'hDEADBEEF);
        run_access("lb",  1'b0, 3'b000, 32'h203, 32'h0, 0, 32'h80FF1234, 32'h200, 32'h0, 4'b0000, 32'hFFFFFF80);
        run_access("lbu", 1'b0, 3'b100, 32'h203, 32'h0, 0, 32'h80FF1234, 32'h200, 32'h0, 4'b0000, 32'h00000080);
        run_access("lhu", 1'b0, 3'b101, 32'h202, 32'h0, 0, 32'h80FF1234, 32'h200, 32'h0, 4'b0000, 32'h000080FF);
        run_access("lh",  1'b0, 3'b001, 32'h202, 32'h0, 1, 32'h80FF1234, 32'h200, 32'h0, 4'b0000, 32'hFFFF80FF);
        run_access("lb0", 1'b0, 3'b000, 32'h200, 32'h0, 2, 32'h80FF12B4, 32'h200, 32'h0, 4'b0000, 32'hFFFFFFB4);
        run_access("lbu1",1'b0, 3'b100, 32'h201, 32'h0, 0, 32'h80FF12B4, 32'h200, 32'h0, 4'b0000, 32'h00000012);
        run_access("sb",  1'b1, 3'b000, 32'h301, 32'h000000AB, 0, 32'h0, 32'h300, 32'hABABABAB, 4'b0010, 32'h00000012);
        run_access("sh",  1'b1, 3'b001, 32'h302, 32'h0000BEEF, 0, 32'h0, 32'h300, 32'hBEEFBEEF, 4'b1100, 32'h00000012);
        run_access("sw",  1'b1, 3'b010, 32'h304, 32'h12345678, 3, 32'h0, 32'h304, 32'h12345678, 4'b1111, 32'h00000012);
        run_access("f011",1'b0, 3'b011, 32'h600, 32'h0, 0, 32'hCAFEF00D, 32'h600, 32'h0, 4'b0000, 32'hCAFEF00D);

        run_misalign("mis_lw", 1'b0, 3'b010, 32'h101);
        run_misalign("mis_sh", 1'b1, 3'b001, 32'h103);

        // Timeout: no ack, count mem_req cycles
        MemRead = 1'b1; Funct3 = 3'b010; Addr = 32'h400;
        @(posedge clk); #1;
        MemRead = 1'b0;
        n = 0;
        @(negedge clk);
        while (mem_req && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("to_req_cycles", n, 32'd16);
        chk("to_buserr", {31'd0, BusErr}, 32'd1);
        chk("to_rdata", ReadData, 32'd0);
        chk("to_stall_done", {31'd0, Stall}, 32'd0);
        @(negedge clk);
        chk("to_buserr_end", {31'd0, BusErr}, 32'd0);
        @(posedge clk); #1;

        // Load a nonzero value, then reset during the 3rd ACCESS cycle
        run_access("lw2", 1'b0, 3'b010, 32'h104, 32'h0, 0, 32'h5A5A5A5A, 32'h104, 32'h0, 4'b0000, 32'h5A5A5A5A);
        MemRead = 1'b1; Funct3 = 3'b010; Addr = 32'h500;
        @(posedge clk); #1;
        MemRead = 1'b0;
        @(negedge clk);
        chk("rm_req1", {31'd0, mem_req}, 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rm_req_off", {31'd0, mem_req}, 32'd0);
        chk("rm_stall", {31'd0, Stall}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rm_late_req", {31'd0, mem_req}, 32'd0);
        chk("rm_late_rdata", ReadData, 32'd0);
        chk("rm_late_stall", {31'd0, Stall}, 32'd0);
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = 32'h0;

        // Back-to-back accesses: each starts right after the previous DONE
        run_access("b2b_lw", 1'b0, 3'b010, 32'h700, 32'h0, 0, 32'h0BADF00D, 32'h700, 32'h0, 4'b0000, 32'h0BADF00D);
        run_access("b2b_sw", 1'b1, 3'b010, 32'h708, 32'hA5A55A5A, 0, 32'h0, 32'h708, 32'hA5A55A5A, 4'b1111, 32'h0BADF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
